// File: rtl/divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and step-counter sizing.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    // Counter must hold WIDTH-1, the number of remaining steps after the first.
    function automatic int step_cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in one dividend bit, trial-subtract the divisor.
module divider_step
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so a non-negative difference fits in WIDTH bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_iter.sv
// Iterative restoring divider, WIDTH+1 cycle latency, single-cycle divide-by-zero response.
// Signed (truncating) division is compiled in only when DIVIDER_SIGNED_EN is defined.
module divider_iter
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = step_cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;
    logic             accept;
    logic             zero_req;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign zero_req = (state == IDLE) && start && (divisor == '0);
    assign accept   = (state == IDLE) && start && (divisor != '0);
    assign busy     = (state != IDLE);

`ifdef DIVIDER_SIGNED_EN
    logic sgn_a;
    logic sgn_b;
    logic q_neg;
    logic r_neg;

    assign sgn_a = is_signed & dividend[WIDTH-1];
    assign sgn_b = is_signed & divisor[WIDTH-1];
    assign mag_a = sgn_a ? ('0 - dividend) : dividend;
    assign mag_b = sgn_b ? ('0 - divisor) : divisor;
    assign q_fin = q_neg ? ('0 - dvd_q) : dvd_q;
    assign r_fin = r_neg ? ('0 - rem_q) : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            q_neg <= sgn_a ^ sgn_b;
            r_neg <= sgn_a;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_a = dividend;
    assign mag_b = divisor;
    assign q_fin = dvd_q;
    assign r_fin = rem_q;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt_q == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (zero_req) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else if (accept) begin
                        dvd_q <= mag_a;
                        dvs_q <= mag_b;
                        rem_q <= '0;
                        cnt_q <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q - 1'b1;
                end
                FIN: begin
                    quotient    <= q_fin;
                    remainder   <= r_fin;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: vector table, hand sequences and random operands, scoreboarded on done.
module tb_divider_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[15];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    divider_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter and result monitor; outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result pending (edge %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.z);
                check("done_edge", cyc, e.due);
            end
        end
    end

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        longint q64;
        longint r64;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            z = 1'b0;
            q = a / b;
            r = a % b;
`ifdef DIVIDER_SIGNED_EN
            if (s) begin
                sa  = $signed(a);
                sb  = $signed(b);
                q64 = sa / sb;
                r64 = sa % sb;
                q   = q64[W-1:0];
                r   = r64[W-1:0];
            end
`else
            if (s) q = a / b;
`endif
        end
    endfunction

    // Called at a falling edge; the request is sampled by the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        exp_q.push_back('{eq, er, ez, cyc + 1 + (ez ? 0 : W + 1)});
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int bc;
        logic [W-1:0] ra, rb, eq, er;
        logic rs, ez;

        tbl[0]  = '{32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,          1'b0};
        tbl[1]  = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234,       1'b1};
        tbl[2]  = '{32'd5,          32'd1,          1'b0, 32'd5,          32'd0,          1'b0};
        tbl[3]  = '{32'd0,          32'd7,          1'b0, 32'd0,          32'd0,          1'b0};
        tbl[4]  = '{32'd7,          32'd9,          1'b0, 32'd0,          32'd7,          1'b0};
        tbl[5]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
        tbl[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
        tbl[7]  = '{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,          1'b0};
        tbl[8]  = '{32'h1234_5678,  32'h1000,       1'b0, 32'h0001_2345,  32'h678,        1'b0};
        tbl[13] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
        tbl[14] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0};
`ifdef DIVIDER_SIGNED_EN
        tbl[9]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        tbl[11] = '{32'hFFFF_FFF7,  32'hFFFF_FFFC,  1'b1, 32'd2,          32'hFFFF_FFFF,  1'b0};
        tbl[12] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
`else
        tbl[9]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0};
        tbl[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0};
        tbl[11] = '{32'hFFFF_FFF7,  32'hFFFF_FFFC,  1'b1, 32'd0,          32'hFFFF_FFF7,  1'b0};
        tbl[12] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7,          1'b0};
`endif

        rst       = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Latency and busy window for 1000 / 10.
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            bc++;
            @(negedge clk);
        end
        check("busy_cycles", bc, W + 1);
        drain();

        // Back-to-back: start held high, operands changed after the first acceptance.
        e0        = cyc + 1;
        start     = 1'b1;
        dividend  = 32'd63;
        divisor   = 32'd7;
        is_signed = 1'b0;
        exp_q.push_back('{32'd9, 32'd0, 1'b0, e0 + W + 1});
        exp_q.push_back('{32'd14, 32'd2, 1'b0, e0 + 2 * W + 3});
        @(negedge clk);
        dividend = 32'd100;
        while (cyc < e0 + W + 1) @(negedge clk);
        check("b2b_done_cycle", done, 1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        drain();

        // Divide-by-zero, then a normal division clears the flag.
        issue(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        check("dbz_idle_busy", busy, 0);
        issue(32'd5, 32'd1, 1'b0, 32'd5, 32'd0, 1'b0);
        drain();

        // Reset during the 10th CALC cycle aborts without a done.
        e0        = cyc + 1;
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
        drain();

        // A start pulse while busy is ignored.
        issue(32'd200, 32'd3, 1'b0, 32'd66, 32'd2, 1'b0);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        drain();

        foreach (tbl[i]) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].z);
            drain();
        end

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            rs = 1'($urandom);
            model(ra, rb, rs, eq, er, ez);
            issue(ra, rb, rs, eq, er, ez);
            drain();
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
